// File: rtl/module_control_decodificador.sv
// Hamming(7,4) receive-path controller: accepts one coded word,
// computes the syndrome, corrects one bit, delivers the nibble.
module module_control_decodificador #(
  parameter int ANCHO_CUENTA = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [6:0]              datos_cod,
  input  logic                    habilitar_correccion,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3:0]              datos_out,
  output logic [2:0]              sindrome,
  output logic                    error_detectado,
  output logic [ANCHO_CUENTA-1:0] cuenta_errores
);

  typedef enum logic [1:0] {
    ESPERA,
    SINDROME,
    CORRIGE,
    ENTREGA
  } estado_t;

  localparam logic [ANCHO_CUENTA-1:0] CUENTA_MAX = '1;

  estado_t                 estado_q, estado_d;
  logic [6:0]              palabra_q, palabra_d;
  logic                    corr_q, corr_d;
  logic [2:0]              sind_int_q, sind_int_d;
  logic [2:0]              sindrome_q, sindrome_d;
  logic [3:0]              datos_q, datos_d;
  logic                    err_q, err_d;
  logic [ANCHO_CUENTA-1:0] cuenta_q, cuenta_d;

  logic [2:0] sind_calc;
  logic [6:0] mascara;
  logic [6:0] palabra_corr;

  // Syndrome of the captured word; bit k is Hamming position k+1.
  always_comb begin
    sind_calc    = 3'b000;
    sind_calc[0] = palabra_q[0] ^ palabra_q[2]
                 ^ palabra_q[4] ^ palabra_q[6];
    sind_calc[1] = palabra_q[1] ^ palabra_q[2]
                 ^ palabra_q[5] ^ palabra_q[6];
    sind_calc[2] = palabra_q[3] ^ palabra_q[4]
                 ^ palabra_q[5] ^ palabra_q[6];
  end

  // Flip mask: syndrome S names bit S-1, only when correction is on.
  always_comb begin
    mascara = 7'b0000000;
    if (corr_q && (sind_int_q != 3'b000)) begin
      mascara = 7'b0000001 << (sind_int_q - 3'd1);
    end
    palabra_corr = palabra_q ^ mascara;
  end

  // Next-state and datapath-load logic of the sequencing FSM.
  always_comb begin
    estado_d   = estado_q;
    palabra_d  = palabra_q;
    corr_d     = corr_q;
    sind_int_d = sind_int_q;
    sindrome_d = sindrome_q;
    datos_d    = datos_q;
    err_d      = err_q;
    cuenta_d   = cuenta_q;
    unique case (estado_q)
      ESPERA: begin
        if (in_valid) begin
          palabra_d = datos_cod;
          corr_d    = habilitar_correccion;
          estado_d  = SINDROME;
        end
      end
      SINDROME: begin
        sind_int_d = sind_calc;
        estado_d   = CORRIGE;
      end
      CORRIGE: begin
        sindrome_d = sind_int_q;
        datos_d    = {palabra_corr[6], palabra_corr[5],
                      palabra_corr[4], palabra_corr[2]};
        err_d      = (sind_int_q != 3'b000);
        if ((sind_int_q != 3'b000) && (cuenta_q != CUENTA_MAX)) begin
          cuenta_d = cuenta_q + ANCHO_CUENTA'(1);
        end
        estado_d = ENTREGA;
      end
      ENTREGA: begin
        if (out_ready) begin
          estado_d = ESPERA;
        end
      end
      default: estado_d = ESPERA;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q   <= ESPERA;
      palabra_q  <= '0;
      corr_q     <= 1'b0;
      sind_int_q <= '0;
      sindrome_q <= '0;
      datos_q    <= '0;
      err_q      <= 1'b0;
      cuenta_q   <= '0;
    end else begin
      estado_q   <= estado_d;
      palabra_q  <= palabra_d;
      corr_q     <= corr_d;
      sind_int_q <= sind_int_d;
      sindrome_q <= sindrome_d;
      datos_q    <= datos_d;
      err_q      <= err_d;
      cuenta_q   <= cuenta_d;
    end
  end

  assign in_ready        = (estado_q == ESPERA) && !rst;
  assign out_valid       = (estado_q == ENTREGA);
  assign datos_out       = datos_q;
  assign sindrome        = sindrome_q;
  assign error_detectado = err_q;
  assign cuenta_errores  = cuenta_q;

endmodule

// File: tb/tb_module_control_decodificador.sv
// Directed bench for the Hamming(7,4) controller, counter width 3
// so that saturation is reached during the single-bit sweep.
module tb_module_control_decodificador;

  localparam int W   = 3;
  localparam int MAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [6:0]   datos_cod;
  logic         habilitar_correccion;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   datos_out;
  logic [2:0]   sindrome;
  logic         error_detectado;
  logic [W-1:0] cuenta_errores;

  int n_vec   = 0;
  int n_bad   = 0;
  int exp_cnt = 0;
  int lat;

  always #5 clk = ~clk;

  module_control_decodificador #(.ANCHO_CUENTA(W)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .datos_cod            (datos_cod),
    .habilitar_correccion (habilitar_correccion),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .datos_out            (datos_out),
    .sindrome             (sindrome),
    .error_detectado      (error_detectado),
    .cuenta_errores       (cuenta_errores)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] w;
    w    = 7'b0;
    w[6] = d[3];
    w[5] = d[2];
    w[4] = d[1];
    w[2] = d[0];
    w[0] = w[2] ^ w[4] ^ w[6];
    w[1] = w[2] ^ w[5] ^ w[6];
    w[3] = w[4] ^ w[5] ^ w[6];
    return w;
  endfunction

  // Present a word; returns #1 after the accepting edge.
  task automatic present(input logic [6:0] w, input logic c);
    int t;
    t = 0;
    datos_cod            = w;
    habilitar_correccion = c;
    in_valid             = 1'b1;
    while (!in_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("accept_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    datos_cod = 7'h00;
  endtask

  // Edges after the accepting edge until out_valid is seen.
  task automatic wait_out(output int l);
    l = 0;
    while (!out_valid && l < 20) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic expect_cnt(input logic [2:0] s);
    if (s != 3'b000 && exp_cnt < MAX) exp_cnt++;
  endtask

  // Full transfer with out_ready held high.
  task automatic run(input logic [6:0] w, input logic c,
                     input logic [3:0] ed, input logic [2:0] es);
    present(w, c);
    wait_out(lat);
    check("latency", lat, 2);
    check("datos_out", datos_out, ed);
    check("sindrome", sindrome, es);
    check("error_det", error_detectado, es != 3'b000);
    expect_cnt(es);
    check("cuenta", cuenta_errores, exp_cnt);
    @(posedge clk); #1;
    check("in_ready_after", in_ready, 1);
    check("out_valid_after", out_valid, 0);
  endtask

  initial begin
    rst                  = 1'b1;
    in_valid             = 1'b0;
    datos_cod            = 7'h00;
    habilitar_correccion = 1'b0;
    out_ready            = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_datos", datos_out, 0);
    check("rst_sind", sindrome, 0);
    check("rst_err", error_detectado, 0);
    check("rst_cuenta", cuenta_errores, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst_ready", in_ready, 1);

    run(7'b1010101, 1'b1, 4'b1011, 3'b000);
    run(7'b1000101, 1'b1, 4'b1011, 3'b101);
    run(7'b1000101, 1'b0, 4'b1001, 3'b101);
    run(7'b1010110, 1'b1, 4'b1010, 3'b011);

    out_ready = 1'b0;
    present(7'b1010101, 1'b1);
    wait_out(lat);
    check("bp_latency", lat, 2);
    for (int i = 0; i < 10; i++) begin
      datos_cod = 7'($urandom);
      in_valid  = i[0];
      @(posedge clk); #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_datos", datos_out, 4'b1011);
      check("bp_sind", sindrome, 3'b000);
      check("bp_err", error_detectado, 0);
      check("bp_cuenta", cuenta_errores, exp_cnt);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", in_ready, 1);
    check("bp_release_valid", out_valid, 0);

    for (int d = 0; d < 16; d++) begin
      run(encode(4'(d)), 1'b1, 4'(d), 3'b000);
      for (int k = 0; k < 7; k++) begin
        run(encode(4'(d)) ^ (7'b0000001 << k), 1'b1,
            4'(d), 3'(k + 1));
      end
    end
    check("saturated", cuenta_errores, MAX);

    out_ready = 1'b0;
    present(7'b1000101, 1'b1);
    wait_out(lat);
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_datos", datos_out, 0);
    check("mid_rst_sind", sindrome, 0);
    check("mid_rst_err", error_detectado, 0);
    check("mid_rst_cuenta", cuenta_errores, 0);
    rst       = 1'b0;
    exp_cnt   = 0;
    out_ready = 1'b1;
    #1;
    check("mid_rst_ready_after", in_ready, 1);
    run(7'b1000101, 1'b1, 4'b1011, 3'b101);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
